// File: rtl/rx_block_lock_pkg.sv
// Shared definitions for the 64b/66b block-lock controller and its consumers.
package rx_block_lock_pkg;

    // Sync header codes, shared with the 66b decoder.
    localparam logic [1:0] SYNC_DATA    = 2'b01;
    localparam logic [1:0] SYNC_CONTROL = 2'b10;

    // Block-lock state encodings.
    typedef enum logic [1:0] {
        ST_SLIP_WAIT = 2'b00,
        ST_SEARCH    = 2'b01,
        ST_LOCKED    = 2'b10
    } lock_state_t;

    // A header is valid only for the two legal sync codes.
    function automatic logic header_valid(input logic [1:0] sync);
        return (sync == SYNC_DATA) || (sync == SYNC_CONTROL);
    endfunction

endpackage

// File: rtl/rx_block_lock_ber.sv
// High-BER monitor: counts invalid headers over fixed windows of valid words
// while the link is locked; held cleared whenever it is disabled.
module rx_ber_monitor
    import rx_block_lock_pkg::*;
#(
    parameter int BER_WINDOW = 19531,
    parameter int BER_ERRS   = 16
) (
    input  logic RX_CLK,
    input  logic i_reset,
    input  logic i_enable,
    input  logic RX_VALID,
    input  logic i_bad,
    output logic o_hi_ber,
    output logic o_hi_ber_next
);

    localparam int WIN_W = $clog2(BER_WINDOW + 1);
    localparam int ERR_W = $clog2(BER_ERRS + 1);

    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_next_s;
    logic [ERR_W-1:0] err_cnt_r;
    logic [ERR_W-1:0] err_next_s;
    logic [ERR_W-1:0] err_inc_s;
    logic             hi_ber_r;
    logic             hi_ber_next_s;

    // Next-state for window/error counters and the hi-BER flag.
    always_comb begin
        win_next_s    = win_cnt_r;
        err_next_s    = err_cnt_r;
        hi_ber_next_s = hi_ber_r;
        err_inc_s     = err_cnt_r;
        if (!i_enable) begin
            win_next_s    = {WIN_W{1'b0}};
            err_next_s    = {ERR_W{1'b0}};
            hi_ber_next_s = 1'b0;
        end else if (RX_VALID) begin
            // Error count saturates; the window-final error is included below.
            if (i_bad && (err_cnt_r != ERR_W'(BER_ERRS))) begin
                err_inc_s = err_cnt_r + ERR_W'(1);
            end else begin
                err_inc_s = err_cnt_r;
            end
            if (win_cnt_r == WIN_W'(BER_WINDOW - 1)) begin
                win_next_s    = {WIN_W{1'b0}};
                err_next_s    = {ERR_W{1'b0}};
                hi_ber_next_s = (err_inc_s == ERR_W'(BER_ERRS));
            end else begin
                win_next_s    = win_cnt_r + WIN_W'(1);
                err_next_s    = err_inc_s;
                hi_ber_next_s = hi_ber_r || (err_inc_s == ERR_W'(BER_ERRS));
            end
        end else begin
            hi_ber_next_s = hi_ber_r;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge RX_CLK) begin
        if (i_reset) begin
            win_cnt_r <= {WIN_W{1'b0}};
            err_cnt_r <= {ERR_W{1'b0}};
            hi_ber_r  <= 1'b0;
        end else begin
            win_cnt_r <= win_next_s;
            err_cnt_r <= err_next_s;
            hi_ber_r  <= hi_ber_next_s;
        end
    end

    assign o_hi_ber      = hi_ber_r;
    // Exposed so the parent can register the PHY fault on the same edge.
    assign o_hi_ber_next = hi_ber_next_s;

endmodule

// File: rtl/rx_block_lock.sv
// 64b/66b receive block lock: aligns the gearbox via bitslip pulses, tracks
// lock and high-BER, and drives the decoder's PHY-fault input.
module rx_block_lock
    import rx_block_lock_pkg::*;
#(
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_WINDOW = 64,
    parameter int UNLOCK_ERRS   = 16,
    parameter int SLIP_WAIT     = 32,
    parameter int BER_WINDOW    = 19531,
    parameter int BER_ERRS      = 16
) (
    input  logic        RX_CLK,
    input  logic        i_reset,
    input  logic        RX_VALID,
    input  logic [1:0]  RX_SYNC,
    output logic        o_bitslip,
    output logic        o_block_lock,
    output logic        o_hi_ber,
    output logic        o_phy_fault,
    output logic [15:0] o_slip_count
);

    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = $clog2(UNLOCK_WINDOW + 1);
    localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);

    lock_state_t      state_r;
    lock_state_t      state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_next_s;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [GOOD_W-1:0] good_next_s;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [WIN_W-1:0]  win_next_s;
    logic [ERR_W-1:0]  err_cnt_r;
    logic [ERR_W-1:0]  err_next_s;
    logic [15:0]       slip_cnt_r;
    logic [15:0]       slip_next_s;
    logic              slip_s;
    logic              hv_s;
    logic              bitslip_r;
    logic              block_lock_r;
    logic              phy_fault_r;
    logic              ber_enable_s;
    logic              hi_ber_s;
    logic              hi_ber_next_s;

    assign hv_s = header_valid(RX_SYNC);

    // Lock state machine: next state, counters and slip decision.
    always_comb begin
        state_next_s = state_r;
        wait_next_s  = wait_cnt_r;
        good_next_s  = good_cnt_r;
        win_next_s   = win_cnt_r;
        err_next_s   = err_cnt_r;
        slip_s       = 1'b0;
        if (RX_VALID) begin
            case (state_r)
                ST_SLIP_WAIT: begin
                    // Headers are ignored while the gearbox settles.
                    if (wait_cnt_r == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_next_s  = {WAIT_W{1'b0}};
                        good_next_s  = {GOOD_W{1'b0}};
                        state_next_s = ST_SEARCH;
                    end else begin
                        wait_next_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (!hv_s) begin
                        slip_s       = 1'b1;
                        good_next_s  = {GOOD_W{1'b0}};
                        wait_next_s  = {WAIT_W{1'b0}};
                        state_next_s = ST_SLIP_WAIT;
                    end else if (good_cnt_r == GOOD_W'(LOCK_COUNT - 1)) begin
                        good_next_s  = {GOOD_W{1'b0}};
                        win_next_s   = {WIN_W{1'b0}};
                        err_next_s   = {ERR_W{1'b0}};
                        state_next_s = ST_LOCKED;
                    end else begin
                        good_next_s = good_cnt_r + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Error check precedes window clear so a final-word error counts.
                    if (!hv_s && (err_cnt_r == ERR_W'(UNLOCK_ERRS - 1))) begin
                        slip_s       = 1'b1;
                        win_next_s   = {WIN_W{1'b0}};
                        err_next_s   = {ERR_W{1'b0}};
                        wait_next_s  = {WAIT_W{1'b0}};
                        state_next_s = ST_SLIP_WAIT;
                    end else if (win_cnt_r == WIN_W'(UNLOCK_WINDOW - 1)) begin
                        win_next_s = {WIN_W{1'b0}};
                        err_next_s = {ERR_W{1'b0}};
                    end else begin
                        win_next_s = win_cnt_r + WIN_W'(1);
                        err_next_s = hv_s ? err_cnt_r : (err_cnt_r + ERR_W'(1));
                    end
                end
                default: begin
                    wait_next_s  = {WAIT_W{1'b0}};
                    good_next_s  = {GOOD_W{1'b0}};
                    win_next_s   = {WIN_W{1'b0}};
                    err_next_s   = {ERR_W{1'b0}};
                    state_next_s = ST_SLIP_WAIT;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Saturating slip counter next value.
    always_comb begin
        if (slip_s && (slip_cnt_r != 16'hffff)) begin
            slip_next_s = slip_cnt_r + 16'd1;
        end else begin
            slip_next_s = slip_cnt_r;
        end
    end

    // The BER monitor runs only while the link stays locked, so it clears on
    // the same edge that lock is lost and starts on the word after lock.
    assign ber_enable_s = (state_r == ST_LOCKED) && (state_next_s == ST_LOCKED);

    rx_ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_ERRS   (BER_ERRS)
    ) u_ber (
        .RX_CLK        (RX_CLK),
        .i_reset       (i_reset),
        .i_enable      (ber_enable_s),
        .RX_VALID      (RX_VALID),
        .i_bad         (!hv_s),
        .o_hi_ber      (hi_ber_s),
        .o_hi_ber_next (hi_ber_next_s)
    );

    // State, counter and registered-output updates.
    always_ff @(posedge RX_CLK) begin
        if (i_reset) begin
            state_r      <= ST_SLIP_WAIT;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            good_cnt_r   <= {GOOD_W{1'b0}};
            win_cnt_r    <= {WIN_W{1'b0}};
            err_cnt_r    <= {ERR_W{1'b0}};
            slip_cnt_r   <= 16'd0;
            bitslip_r    <= 1'b0;
            block_lock_r <= 1'b0;
            phy_fault_r  <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            wait_cnt_r   <= wait_next_s;
            good_cnt_r   <= good_next_s;
            win_cnt_r    <= win_next_s;
            err_cnt_r    <= err_next_s;
            slip_cnt_r   <= slip_next_s;
            bitslip_r    <= slip_s;
            block_lock_r <= (state_next_s == ST_LOCKED);
            phy_fault_r  <= (state_next_s != ST_LOCKED) || hi_ber_next_s;
        end
    end

    assign o_bitslip    = bitslip_r;
    assign o_block_lock = block_lock_r;
    assign o_hi_ber     = hi_ber_s;
    assign o_phy_fault  = phy_fault_r;
    assign o_slip_count = slip_cnt_r;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed self-checking bench for rx_block_lock.
module tb_rx_block_lock;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [1:0]  rx_sync = 2'b00;
    logic        o_bitslip;
    logic        o_block_lock;
    logic        o_hi_ber;
    logic        o_phy_fault;
    logic [15:0] o_slip_count;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    rx_block_lock #(
        .LOCK_COUNT    (64),
        .UNLOCK_WINDOW (64),
        .UNLOCK_ERRS   (16),
        .SLIP_WAIT     (32),
        .BER_WINDOW    (256),
        .BER_ERRS      (16)
    ) dut (
        .RX_CLK       (clk),
        .i_reset      (i_reset),
        .RX_VALID     (rx_valid),
        .RX_SYNC      (rx_sync),
        .o_bitslip    (o_bitslip),
        .o_block_lock (o_block_lock),
        .o_hi_ber     (o_hi_ber),
        .o_phy_fault  (o_phy_fault),
        .o_slip_count (o_slip_count)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs sampled 1 ns after the edge.
    task automatic step(input logic v, input logic [1:0] s);
        rx_valid = v;
        rx_sync  = s;
        @(posedge clk);
        #1;
        if (o_bitslip === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(1'b0, 2'b00);
        i_reset = 1'b0;
        pulses = 0;
    endtask

    // Reset, 32 settle words, 64 good headers.
    task automatic reach_lock();
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 2'b00);
        for (int i = 0; i < 64; i++) step(1'b1, 2'b01);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_bitslip !== 1'b0) begin fails++; $display("FAIL reset_bitslip got %b exp 0", o_bitslip); end
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL reset_lock got %b exp 0", o_block_lock); end
        checks++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL reset_hiber got %b exp 0", o_hi_ber); end
        checks++; if (o_phy_fault !== 1'b1) begin fails++; $display("FAIL reset_phyfault got %b exp 1", o_phy_fault); end
        checks++; if (o_slip_count !== 16'd0) begin fails++; $display("FAIL reset_slipcnt got %0d exp 0", o_slip_count); end
    endtask

    task automatic test_lock();
        do_reset();
        // Invalid headers during settling must be ignored.
        for (int i = 0; i < 32; i++) step(1'b1, 2'b00);
        for (int i = 0; i < 63; i++) step(1'b1, 2'b01);
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL lock_early got %b exp 0", o_block_lock); end
        checks++; if (o_phy_fault !== 1'b1) begin fails++; $display("FAIL lock_early_fault got %b exp 1", o_phy_fault); end
        step(1'b1, 2'b01);
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL lock_rise got %b exp 1", o_block_lock); end
        checks++; if (o_phy_fault !== 1'b0) begin fails++; $display("FAIL lock_fault_fall got %b exp 0", o_phy_fault); end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL lock_no_slip got %0d exp 0", pulses); end
    endtask

    task automatic test_slip();
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 2'b01);
        for (int i = 0; i < 10; i++) step(1'b1, 2'b10);
        step(1'b1, 2'b11);
        checks++; if (o_bitslip !== 1'b1) begin fails++; $display("FAIL slip_pulse got %b exp 1", o_bitslip); end
        checks++; if (o_slip_count !== 16'd1) begin fails++; $display("FAIL slip_count got %0d exp 1", o_slip_count); end
        step(1'b1, 2'b11);
        checks++; if (o_bitslip !== 1'b0) begin fails++; $display("FAIL slip_width got %b exp 0", o_bitslip); end
        for (int i = 0; i < 31; i++) step(1'b1, 2'b01);
        for (int i = 0; i < 63; i++) step(1'b1, 2'b01);
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL slip_relock_early got %b exp 0", o_block_lock); end
        step(1'b1, 2'b01);
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL slip_relock got %b exp 1", o_block_lock); end
        checks++; if (pulses !== 1) begin fails++; $display("FAIL slip_total got %0d exp 1", pulses); end
    endtask

    // Continues from lock established by test_slip (slip_count already 1).
    task automatic test_unlock();
        for (int i = 0; i < 64; i++) step(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL unlock_15_held got %b exp 1", o_block_lock); end
        for (int i = 0; i < 63; i++) step(1'b1, (i % 4 == 0 && i < 60) ? 2'b11 : 2'b10);
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL unlock_window_cleared got %b exp 1", o_block_lock); end
        checks++; if (pulses !== 1) begin fails++; $display("FAIL unlock_no_early_slip got %0d exp 1", pulses); end
        step(1'b1, 2'b00);
        checks++; if (o_bitslip !== 1'b1) begin fails++; $display("FAIL unlock_slip got %b exp 1", o_bitslip); end
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL unlock_lock got %b exp 0", o_block_lock); end
        checks++; if (o_phy_fault !== 1'b1) begin fails++; $display("FAIL unlock_fault got %b exp 1", o_phy_fault); end
        checks++; if (o_slip_count !== 16'd2) begin fails++; $display("FAIL unlock_slipcnt got %0d exp 2", o_slip_count); end
    endtask

    task automatic test_hi_ber();
        reach_lock();
        for (int i = 0; i < 240; i++) step(1'b1, (i % 16 == 0) ? 2'b00 : 2'b01);
        checks++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL ber_before got %b exp 0", o_hi_ber); end
        step(1'b1, 2'b11);
        checks++; if (o_hi_ber !== 1'b1) begin fails++; $display("FAIL ber_set got %b exp 1", o_hi_ber); end
        checks++; if (o_phy_fault !== 1'b1) begin fails++; $display("FAIL ber_fault_set got %b exp 1", o_phy_fault); end
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL ber_lock_held got %b exp 1", o_block_lock); end
        for (int i = 241; i < 256; i++) step(1'b1, 2'b01);
        checks++; if (o_hi_ber !== 1'b1) begin fails++; $display("FAIL ber_window_end_hold got %b exp 1", o_hi_ber); end
        for (int i = 0; i < 255; i++) step(1'b1, (i == 0 || i == 100 || i == 200) ? 2'b00 : 2'b10);
        checks++; if (o_hi_ber !== 1'b1) begin fails++; $display("FAIL ber_still_set got %b exp 1", o_hi_ber); end
        step(1'b1, 2'b01);
        checks++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL ber_clear got %b exp 0", o_hi_ber); end
        checks++; if (o_phy_fault !== 1'b0) begin fails++; $display("FAIL ber_fault_clear got %b exp 0", o_phy_fault); end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL ber_no_slip got %0d exp 0", pulses); end
    endtask

    // Continues locked from test_hi_ber; raise hi_ber again then reset.
    task automatic test_reset_mid();
        for (int i = 0; i < 241; i++) step(1'b1, (i % 16 == 0) ? 2'b00 : 2'b01);
        checks++; if (o_hi_ber !== 1'b1) begin fails++; $display("FAIL mid_hiber_pre got %b exp 1", o_hi_ber); end
        i_reset = 1'b1;
        step(1'b1, 2'b11);
        i_reset = 1'b0;
        checks++; if (o_bitslip !== 1'b0) begin fails++; $display("FAIL mid_bitslip got %b exp 0", o_bitslip); end
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL mid_lock got %b exp 0", o_block_lock); end
        checks++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL mid_hiber got %b exp 0", o_hi_ber); end
        checks++; if (o_phy_fault !== 1'b1) begin fails++; $display("FAIL mid_fault got %b exp 1", o_phy_fault); end
        checks++; if (o_slip_count !== 16'd0) begin fails++; $display("FAIL mid_slipcnt got %0d exp 0", o_slip_count); end
        step(1'b1, 2'b11);
        checks++; if (o_bitslip !== 1'b0) begin fails++; $display("FAIL mid_no_pulse got %b exp 0", o_bitslip); end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 2'b01);
            for (int g = 0; g < 3; g++) step(1'b0, 2'b01);
        end
        for (int i = 0; i < 63; i++) begin
            step(1'b1, 2'b01);
            for (int g = 0; g < 3; g++) step(1'b0, 2'b11);
        end
        checks++; if (o_block_lock !== 1'b0) begin fails++; $display("FAIL gaps_early got %b exp 0", o_block_lock); end
        step(1'b1, 2'b10);
        checks++; if (o_block_lock !== 1'b1) begin fails++; $display("FAIL gaps_lock got %b exp 1", o_block_lock); end
        checks++; if (pulses !== 0) begin fails++; $display("FAIL gaps_no_slip got %0d exp 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_unlock();
        test_hi_ber();
        test_reset_mid();
        test_valid_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
